// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus scheduler.
//   state_t      : transaction sequencer states
//   bus_pat_t    : strobe / a_d / output-enable pattern for one state
//   bus_pattern(): maps (state, read/write) to its pin pattern
package rtc_bus_pkg;

   localparam int PH_CYC_DEF = 4;
   localparam int NREG_DEF   = 9;

   typedef enum logic [2:0] {
      IDLE, AD_SET, AD_STB, AD_HOLD, DAT_SET, DAT_STB, RECOVER
   } state_t;

   // sel_dat chooses the write data byte (1) or the address byte (0) on ad_out.
   typedef struct packed {
      logic cs_n;
      logic rd_n;
      logic wr_n;
      logic a_d;
      logic oe;
      logic sel_dat;
   } bus_pat_t;

   // Field order: cs_n rd_n wr_n _ a_d oe sel_dat
   localparam bus_pat_t PAT_IDLE       = 6'b111_100;
   localparam bus_pat_t PAT_AD_SET     = 6'b111_010;
   localparam bus_pat_t PAT_AD_STB     = 6'b010_010;  // wr_n low latches the address
   localparam bus_pat_t PAT_AD_HOLD    = 6'b111_010;
   localparam bus_pat_t PAT_DAT_SET_RD = 6'b111_100;
   localparam bus_pat_t PAT_DAT_SET_WR = 6'b111_111;
   localparam bus_pat_t PAT_DAT_STB_RD = 6'b001_100;
   localparam bus_pat_t PAT_DAT_STB_WR = 6'b010_111;
   localparam bus_pat_t PAT_RECOVER    = 6'b111_100;

   function automatic bus_pat_t bus_pattern(input state_t st, input logic is_rd);
      bus_pat_t p;
      case (st)
         AD_SET:  p = PAT_AD_SET;
         AD_STB:  p = PAT_AD_STB;
         AD_HOLD: p = PAT_AD_HOLD;
         DAT_SET: p = is_rd ? PAT_DAT_SET_RD : PAT_DAT_SET_WR;
         DAT_STB: p = is_rd ? PAT_DAT_STB_RD : PAT_DAT_STB_WR;
         RECOVER: p = PAT_RECOVER;
         default: p = PAT_IDLE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Pin-side bundle of the multiplexed RTC bus.
//   master : the scheduler (drives strobes, a_d, ad_out/ad_oe; reads ad_in)
//   slave  : the pad / device side
interface rtc_bus_scheduler_if;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       a_d;

   modport master (input ad_in, output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d);
   modport slave  (output ad_in, input ad_out, ad_oe, cs_n, rd_n, wr_n, a_d);
endinterface

// File: rtl/rtc_phase_timer.sv
// Phase timer: loadable down-counter that marks the last cycle of a bus phase.
//   clk, clr  : clock, asynchronous active-high reset
//   load      : reload to PH_CYC-1 (held while idle and on every phase end)
//   phase_end : high in the final cycle of the current phase
module rtc_phase_timer #(
   parameter int PH_CYC = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic load,
   output logic phase_end
);

   localparam int            CW       = $clog2(PH_CYC + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(PH_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)               cnt_d = LOAD_VAL;
      else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) cnt_q <= LOAD_VAL;
      else     cnt_q <= cnt_d;
   end

   assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: round-robin arbiter between a register-read burst and
// single configuration writes, sequencing each transaction through address
// and data phases on the multiplexed bus.
//   clk, clr                  : clock, asynchronous active-high reset
//   rd_req, rd_base           : burst request pulse, first burst address
//   wr_req, wr_addr, wr_data  : write request level (held until wr_ack)
//   bus                       : pad-side pins (strobes, a_d, ad_out/oe, ad_in)
//   rd_data, rd_idx, rd_valid : captured read byte, its burst index, strobe
//   rd_done, wr_ack, busy     : burst end, write end, non-idle indicator
module rtc_bus_scheduler
   import rtc_bus_pkg::*;
#(
   parameter int PH_CYC = PH_CYC_DEF,
   parameter int NREG   = NREG_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  rd_req,
   input  logic [7:0]            rd_base,
   input  logic                  wr_req,
   input  logic [7:0]            wr_addr,
   input  logic [7:0]            wr_data,
   rtc_bus_scheduler_if.master   bus,
   output logic [7:0]            rd_data,
   output logic [3:0]            rd_idx,
   output logic                  rd_valid,
   output logic                  rd_done,
   output logic                  wr_ack,
   output logic                  busy
);

   localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

   state_t     state_q, state_d;
   logic       rd_pend_q, rd_pend_d;
   logic       last_rd_q, last_rd_d;     // last grant went to the read burst
   logic       is_rd_q, is_rd_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] base_q, base_d, waddr_q, waddr_d, wdata_q, wdata_d;
   logic [7:0] rd_data_q, rd_data_d, ad_out_q, ad_out_d;
   logic [3:0] rd_idx_q, rd_idx_d;
   logic       rd_valid_q, rd_valid_d, rd_done_q, rd_done_d, wr_ack_q, wr_ack_d;
   logic       busy_q, busy_d;
   bus_pat_t   pat_q, pat_d;
   logic [7:0] addr_d;
   logic       phase_end, wr_ok, rd_any;

   rtc_phase_timer #(.PH_CYC(PH_CYC)) u_timer (
      .clk       (clk),
      .clr       (clr),
      .load      ((state_q == IDLE) || phase_end),
      .phase_end (phase_end)
   );

   always_comb begin
      // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      rd_pend_d  = rd_pend_q | rd_req;
      last_rd_d  = last_rd_q;
      is_rd_d    = is_rd_q;
      idx_d      = idx_q;
      base_d     = base_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      rd_idx_d   = rd_idx_q;
      rd_valid_d = 1'b0;
      rd_done_d  = 1'b0;
      wr_ack_d   = 1'b0;
      // A write still held during its own ack cycle is the finished one.
      wr_ok      = wr_req && !wr_ack_q;
      rd_any     = rd_pend_q || rd_req;

      if (state_q == IDLE) begin
         if (rd_any && (!wr_ok || !last_rd_q)) begin
            state_d   = AD_SET;
            is_rd_d   = 1'b1;
            last_rd_d = 1'b1;
            rd_pend_d = 1'b0;
            idx_d     = 4'd0;
            base_d    = rd_base;
         end else if (wr_ok) begin
            state_d   = AD_SET;
            is_rd_d   = 1'b0;
            last_rd_d = 1'b0;
            waddr_d   = wr_addr;
            wdata_d   = wr_data;
         end
      end else if (phase_end) begin
         case (state_q)
            AD_SET:  state_d = AD_STB;
            AD_STB:  state_d = AD_HOLD;
            AD_HOLD: state_d = DAT_SET;
            DAT_SET: state_d = DAT_STB;
            DAT_STB: begin
               state_d = RECOVER;
               if (is_rd_q) begin
                  rd_data_d  = bus.ad_in;
                  rd_idx_d   = idx_q;
                  rd_valid_d = 1'b1;
               end
            end
            RECOVER: begin
               // Bursts run back-to-back without returning to IDLE.
               if (is_rd_q && (idx_q != LAST_IDX)) begin
                  idx_d   = idx_q + 4'd1;
                  state_d = AD_SET;
               end else begin
                  state_d   = IDLE;
                  rd_done_d = is_rd_q;
                  wr_ack_d  = !is_rd_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Pin values are decoded from the next state so they register with it.
      pat_d    = bus_pattern(state_d, is_rd_d);
      addr_d   = is_rd_d ? (base_d + {4'd0, idx_d}) : waddr_d;
      ad_out_d = !pat_d.oe ? 8'd0 : (pat_d.sel_dat ? wdata_d : addr_d);
      busy_d   = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= IDLE;
         rd_pend_q  <= 1'b0;
         last_rd_q  <= 1'b1;
         is_rd_q    <= 1'b0;
         idx_q      <= 4'd0;
         base_q     <= 8'd0;
         waddr_q    <= 8'd0;
         wdata_q    <= 8'd0;
         rd_data_q  <= 8'd0;
         rd_idx_q   <= 4'd0;
         rd_valid_q <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_ack_q   <= 1'b0;
         busy_q     <= 1'b0;
         pat_q      <= PAT_IDLE;
         ad_out_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         rd_pend_q  <= rd_pend_d;
         last_rd_q  <= last_rd_d;
         is_rd_q    <= is_rd_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         rd_idx_q   <= rd_idx_d;
         rd_valid_q <= rd_valid_d;
         rd_done_q  <= rd_done_d;
         wr_ack_q   <= wr_ack_d;
         busy_q     <= busy_d;
         pat_q      <= pat_d;
         ad_out_q   <= ad_out_d;
      end
   end

   assign bus.cs_n   = pat_q.cs_n;
   assign bus.rd_n   = pat_q.rd_n;
   assign bus.wr_n   = pat_q.wr_n;
   assign bus.a_d    = pat_q.a_d;
   assign bus.ad_oe  = pat_q.oe;
   assign bus.ad_out = ad_out_q;
   assign rd_data    = rd_data_q;
   assign rd_idx     = rd_idx_q;
   assign rd_valid   = rd_valid_q;
   assign rd_done    = rd_done_q;
   assign wr_ack     = wr_ack_q;
   assign busy       = busy_q;

   // sel_dat only steers ad_out_d; the registered copy is intentionally unused.
   logic unused_sel;
   assign unused_sel = pat_q.sel_dat;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with PH_CYC=2, NREG=3.
// Cycle index k counts negedges after the grant edge E0 (k=0 is the first
// cycle of AD_SET); one transaction spans 12 cycles.
module tb_rtc_bus_scheduler;

   logic       clk = 1'b0;
   logic       clr;
   logic       rd_req, wr_req;
   logic [7:0] rd_base, wr_addr, wr_data;
   logic [7:0] rd_data;
   logic [3:0] rd_idx;
   logic       rd_valid, rd_done, wr_ack, busy;
   logic [7:0] pad_lat = 8'h00;

   int tests_run    = 0;
   int tests_failed = 0;

   rtc_bus_scheduler_if bus_if ();

   rtc_bus_scheduler #(.PH_CYC(2), .NREG(3)) dut (
      .clk      (clk),
      .clr      (clr),
      .rd_req   (rd_req),
      .rd_base  (rd_base),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .bus      (bus_if),
      .rd_data  (rd_data),
      .rd_idx   (rd_idx),
      .rd_valid (rd_valid),
      .rd_done  (rd_done),
      .wr_ack   (wr_ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Pad model: latches the address on the address strobe, returns ~addr.
   always @(negedge clk)
      if (bus_if.cs_n === 1'b0 && bus_if.wr_n === 1'b0 && bus_if.a_d === 1'b0)
         pad_lat <= bus_if.ad_out;
   assign bus_if.ad_in = ~pad_lat;

   localparam logic [28:0] RESET_VEC = {5'b11110, 8'h00, 8'h00, 4'h0, 4'b0000};

   function automatic logic [28:0] out_vec();
      return {bus_if.cs_n, bus_if.rd_n, bus_if.wr_n, bus_if.a_d, bus_if.ad_oe,
              bus_if.ad_out, rd_data, rd_idx, rd_valid, rd_done, wr_ack, busy};
   endfunction

   // Window logs
   logic [14:0] row_log [128];   // {cs,rd,wr,a_d,oe,busy,wr_ack,ad_out}
   int          rv_k[$];
   logic [3:0]  rv_i[$];
   logic [7:0]  rv_d[$];
   int          done_k[$];
   int          ack_k[$];
   int          busy_cnt;

   // Samples n cycles; pulses rd_req at rd_at0/rd_at1, raises wr_req at wr_at,
   // and drops wr_req one cycle after seeing wr_ack.
   task automatic run_window(input int n, input int rd_at0, input int rd_at1, input int wr_at);
      logic drop_wr = 1'b0;
      rv_k.delete(); rv_i.delete(); rv_d.delete(); done_k.delete(); ack_k.delete();
      busy_cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         row_log[k] = {bus_if.cs_n, bus_if.rd_n, bus_if.wr_n, bus_if.a_d, bus_if.ad_oe,
                       busy, wr_ack, bus_if.ad_out};
         if (rd_valid === 1'b1) begin rv_k.push_back(k); rv_i.push_back(rd_idx); rv_d.push_back(rd_data); end
         if (rd_done === 1'b1) done_k.push_back(k);
         if (busy === 1'b1) busy_cnt++;
         rd_req = (k == rd_at0) || (k == rd_at1);
         if (k == wr_at) wr_req = 1'b1;
         if (drop_wr) begin wr_req = 1'b0; drop_wr = 1'b0; end
         if (wr_ack === 1'b1) begin ack_k.push_back(k); drop_wr = 1'b1; end
      end
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if (out_vec() !== RESET_VEC) begin
         tests_failed++; $display("FAIL reset_async: got %h want %h", out_vec(), RESET_VEC);
      end
      repeat (2) @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (out_vec() !== RESET_VEC) begin
         tests_failed++; $display("FAIL reset_idle: got %h want %h", out_vec(), RESET_VEC);
      end
   endtask

   task automatic test_write();
      logic [14:0] exp_row [8];
      logic [14:0] got;
      int          ph;
      exp_row[0] = {7'b1110110, 8'h21};  // AD_SET
      exp_row[1] = {7'b0100110, 8'h21};  // AD_STB
      exp_row[2] = {7'b1110110, 8'h21};  // AD_HOLD
      exp_row[3] = {7'b1111110, 8'h55};  // DAT_SET
      exp_row[4] = {7'b0101110, 8'h55};  // DAT_STB
      exp_row[5] = {7'b1111010, 8'h00};  // RECOVER
      exp_row[6] = {7'b1111001, 8'h00};  // IDLE, wr_ack
      exp_row[7] = {7'b1111000, 8'h00};  // IDLE, wr_req still high, no re-grant
      wr_addr = 8'h21; wr_data = 8'h55; wr_req = 1'b1;
      run_window(14, -1, -1, -1);
      for (int k = 0; k < 14; k++) begin
         ph  = (k < 12) ? k / 2 : k - 6;
         got = row_log[k];
         if (exp_row[ph][10] == 1'b0) got[7:0] = 8'h00;
         tests_run++;
         if (got !== exp_row[ph]) begin
            tests_failed++; $display("FAIL write_cycle_%0d: got %h want %h", k, got, exp_row[ph]);
         end
      end
   endtask

   task automatic test_read();
      int oe_lo = 0, rd_lo = 0;
      int         ek [3] = '{10, 22, 34};
      logic [7:0] ed [3] = '{8'hDF, 8'hDE, 8'hDD};
      rd_base = 8'h20; rd_req = 1'b1;
      run_window(40, -1, -1, -1);
      tests_run++;
      if (rv_k.size() != 3) begin
         tests_failed++; $display("FAIL read_valid_count: got %0d want 3", rv_k.size());
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (rv_k.size() <= i || rv_k[i] != ek[i] || rv_i[i] !== 4'(i) || rv_d[i] !== ed[i]) begin
            tests_failed++;
            $display("FAIL read_byte_%0d: got k=%0d idx=%0d data=%h want k=%0d idx=%0d data=%h", i,
                     (rv_k.size() > i) ? rv_k[i] : -1, (rv_i.size() > i) ? rv_i[i] : 4'hF,
                     (rv_d.size() > i) ? rv_d[i] : 8'hXX, ek[i], i, ed[i]);
         end
      end
      tests_run++;
      if (done_k.size() != 1 || done_k[0] != 36) begin
         tests_failed++; $display("FAIL read_done: got %0d pulses first at %0d want 1 at 36",
                                  done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
      end
      for (int k = 0; k < 36; k++) begin
         if ((k % 12) >= 6 && (k % 12) < 10 && row_log[k][10] === 1'b0 && row_log[k][11] === 1'b1) oe_lo++;
         if ((k % 12) >= 8 && (k % 12) < 10 && row_log[k][14:12] === 3'b001) rd_lo++;
      end
      tests_run++;
      if (oe_lo != 12) begin
         tests_failed++; $display("FAIL read_data_oe: got %0d cycles want 12", oe_lo);
      end
      tests_run++;
      if (rd_lo != 6) begin
         tests_failed++; $display("FAIL read_rd_strobe: got %0d cycles want 6", rd_lo);
      end
   endtask

   task automatic test_contest();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int r = 0; r < 2; r++) begin
         rd_base = 8'h40; wr_addr = 8'h33; wr_data = 8'h5A;
         rd_req = 1'b1; wr_req = 1'b1;
         run_window(60, -1, -1, -1);
         tests_run++;
         if (ack_k.size() != 1 || ack_k[0] != 12) begin
            tests_failed++; $display("FAIL contest%0d_write_first: got %0d acks first at %0d want 1 at 12",
                                     r, ack_k.size(), (ack_k.size() > 0) ? ack_k[0] : -1);
         end
         tests_run++;
         if (done_k.size() != 1 || done_k[0] != 49) begin
            tests_failed++; $display("FAIL contest%0d_read_after: got %0d dones first at %0d want 1 at 49",
                                     r, done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
         end
         tests_run++;
         if (rv_k.size() != 3 || rv_k[0] != 23 || rv_d[0] !== 8'hBF) begin
            tests_failed++; $display("FAIL contest%0d_first_byte: got n=%0d k=%0d want n=3 k=23 data=bf",
                                     r, rv_k.size(), (rv_k.size() > 0) ? rv_k[0] : -1);
         end
      end
   endtask

   task automatic test_wrap();
      int         ak [3] = '{2, 14, 26};
      logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
      logic [7:0] ed [3] = '{8'h01, 8'h00, 8'hFF};
      rd_base = 8'hFE; rd_req = 1'b1;
      run_window(40, -1, -1, -1);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (row_log[ak[i]][7:0] !== ea[i]) begin
            tests_failed++; $display("FAIL wrap_addr_%0d: got %h want %h", i, row_log[ak[i]][7:0], ea[i]);
         end
         tests_run++;
         if (rv_d.size() <= i || rv_d[i] !== ed[i]) begin
            tests_failed++; $display("FAIL wrap_data_%0d: got %h want %h", i,
                                     (rv_d.size() > i) ? rv_d[i] : 8'hXX, ed[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ek [6] = '{10, 22, 34, 60, 72, 84};
      rd_base = 8'h10; wr_addr = 8'h70; wr_data = 8'h11; rd_req = 1'b1;
      run_window(100, 5, 15, 20);
      tests_run++;
      if (done_k.size() != 2 || done_k[0] != 36 || done_k[1] != 86) begin
         tests_failed++; $display("FAIL b2b_bursts: got %0d dones want 2 at 36,86", done_k.size());
      end
      tests_run++;
      if (ack_k.size() != 1 || ack_k[0] != 49) begin
         tests_failed++; $display("FAIL b2b_write_between: got %0d acks first at %0d want 1 at 49",
                                  ack_k.size(), (ack_k.size() > 0) ? ack_k[0] : -1);
      end
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (rv_k.size() <= i || rv_k[i] != ek[i] || rv_i[i] !== 4'(i % 3)) begin
            tests_failed++; $display("FAIL b2b_valid_%0d: got k=%0d want k=%0d idx=%0d", i,
                                     (rv_k.size() > i) ? rv_k[i] : -1, ek[i], i % 3);
         end
      end
   endtask

   task automatic test_clr_mid();
      rd_base = 8'h30; rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (9) @(negedge clk);
      tests_run++;
      if (bus_if.rd_n !== 1'b0 || bus_if.cs_n !== 1'b0) begin
         tests_failed++; $display("FAIL clr_pre_stb: got rd_n=%b cs_n=%b want 0 0", bus_if.rd_n, bus_if.cs_n);
      end
      clr = 1'b1;
      #1;
      tests_run++;
      if (out_vec() !== RESET_VEC) begin
         tests_failed++; $display("FAIL clr_async: got %h want %h", out_vec(), RESET_VEC);
      end
      #1 clr = 1'b0;
      run_window(40, -1, -1, -1);
      tests_run++;
      if (busy_cnt != 0 || rv_k.size() != 0 || done_k.size() != 0 || ack_k.size() != 0) begin
         tests_failed++; $display("FAIL clr_after: got busy=%0d valid=%0d done=%0d ack=%0d want all 0",
                                  busy_cnt, rv_k.size(), done_k.size(), ack_k.size());
      end
   endtask

   initial begin
      clr = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_base = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_contest();
      test_wrap();
      test_back_to_back();
      test_clr_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
